// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl
// Logic-analyzer capture controller. Streams strobed LA samples into a
// circular sample RAM, keeps a programmable number of samples before and after
// the trigger sample, then plays the frame back oldest-first over a
// request/valid handshake through the same RAM address port.
module la_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ARM,
    input  logic              SAMPLE_EN,
    input  logic [DATA_W-1:0] LA_DATA_IN,
    input  logic              LA_Sync_RDY,
    input  logic [ADDR_W-1:0] PRETRIG_DEPTH,
    input  logic [ADDR_W-1:0] POSTTRIG_CNT,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              RD_REQ,
    output logic [DATA_W-1:0] LA_DATA_OUT,
    output logic              RD_VALID,
    output logic              RD_LAST,
    output logic              BUSY,
    output logic              TRIGGERED,
    output logic              DONE,
    output logic [ADDR_W-1:0] TRIG_ADDR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Frame geometry latched at ARM
    logic [ADDR_W-1:0]   r_pre;
    logic [ADDR_W-1:0]   r_post;

    // Capture-side pointers and counters
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_pre_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic                r_triggered;

    // Readout pointer and remaining sample count (can reach 2^ADDR_W)
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_remain;

    // Readout pipeline: p1 = RAM data arriving, p2 = registered output
    logic                r_req_p1;
    logic                r_last_p1;
    logic [DATA_W-1:0]   r_data_out_p2;
    logic                r_rd_valid_p2;
    logic                r_rd_last_p2;

    logic                w_capturing;
    logic                w_wr;
    logic                w_arm_ok;
    logic                w_trig;
    logic                w_pre_end;
    logic                w_post_end;
    logic                w_to_done;
    logic                w_rd_acc;
    logic                w_frame_end;
    logic [ADDR_W-1:0]   w_post_room;
    logic [ADDR_W-1:0]   w_post_clamp;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_wr        = w_capturing && SAMPLE_EN;
    assign w_arm_ok    = ARM && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_trig      = (r_state == S_WAIT) && SAMPLE_EN && LA_Sync_RDY;
    assign w_pre_end   = (r_state == S_PRE) && SAMPLE_EN && (r_pre_cnt == r_pre - 1'b1);
    assign w_post_end  = (r_state == S_POST) && SAMPLE_EN && (r_post_cnt == {{(ADDR_W-1){1'b0}}, 1'b1});
    assign w_to_done   = (w_trig && (r_post == '0)) || w_post_end;
    assign w_rd_acc    = (r_state == S_DONE) && RD_REQ && (r_remain != '0) && !ARM;
    assign w_frame_end = r_rd_valid_p2 && r_rd_last_p2;

    // The whole frame (pre + trigger + post) must fit in the buffer, so the
    // post depth is limited to the room left after the pre depth.
    assign w_post_room  = ~PRETRIG_DEPTH;
    assign w_post_clamp = (POSTTRIG_CNT > w_post_room) ? w_post_room : POSTTRIG_CNT;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ARM) begin
                    w_next = (PRETRIG_DEPTH == '0) ? S_WAIT : S_PRE;
                end
            end
            S_PRE: begin
                if (w_pre_end) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_trig) begin
                    w_next = (r_post == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (w_post_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (ARM) begin
                    w_next = (PRETRIG_DEPTH == '0) ? S_WAIT : S_PRE;
                end else if (w_frame_end) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: zero-latency write port, shared address for readout
    always_comb begin
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        if (w_capturing) begin
            BUSY     = 1'b1;
            MEM_ADDR = r_wr_ptr;
            if (SAMPLE_EN) begin
                MEM_WE    = 1'b1;
                MEM_WDATA = LA_DATA_IN;
            end
        end else if (r_state == S_DONE) begin
            DONE     = 1'b1;
            MEM_ADDR = r_rd_ptr;
        end
    end

    // Capture counters, trigger bookkeeping and readout pipeline
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pre         <= '0;
            r_post        <= '0;
            r_wr_ptr      <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_trig_addr   <= '0;
            r_triggered   <= 1'b0;
            r_rd_ptr      <= '0;
            r_remain      <= '0;
            r_req_p1      <= 1'b0;
            r_last_p1     <= 1'b0;
            r_data_out_p2 <= '0;
            r_rd_valid_p2 <= 1'b0;
            r_rd_last_p2  <= 1'b0;
        end else begin
            if (r_req_p1) begin
                r_data_out_p2 <= MEM_RDATA;
            end
            if (w_arm_ok) begin
                // A new frame: forget the old one, including reads in flight
                r_pre         <= PRETRIG_DEPTH;
                r_post        <= w_post_clamp;
                r_wr_ptr      <= '0;
                r_pre_cnt     <= '0;
                r_triggered   <= 1'b0;
                r_remain      <= '0;
                r_req_p1      <= 1'b0;
                r_last_p1     <= 1'b0;
                r_rd_valid_p2 <= 1'b0;
                r_rd_last_p2  <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if ((r_state == S_PRE) && SAMPLE_EN) begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
                if (w_trig) begin
                    r_trig_addr <= r_wr_ptr;
                    r_triggered <= 1'b1;
                    r_post_cnt  <= r_post;
                end else if ((r_state == S_POST) && SAMPLE_EN) begin
                    r_post_cnt <= r_post_cnt - 1'b1;
                end
                // The last sample sits at wr_ptr; the oldest is pre+post back
                if (w_to_done) begin
                    r_rd_ptr <= r_wr_ptr - r_pre - r_post;
                    r_remain <= {1'b0, r_pre} + {1'b0, r_post} + 1'b1;
                end else if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_remain <= r_remain - 1'b1;
                end
                r_req_p1      <= w_rd_acc;
                r_last_p1     <= w_rd_acc && (r_remain == {{ADDR_W{1'b0}}, 1'b1});
                r_rd_valid_p2 <= r_req_p1;
                r_rd_last_p2  <= r_last_p1;
                if (w_frame_end) begin
                    r_triggered <= 1'b0;
                end
            end
        end
    end

    assign LA_DATA_OUT = r_data_out_p2;
    assign RD_VALID    = r_rd_valid_p2;
    assign RD_LAST     = r_rd_last_p2;
    assign TRIGGERED   = r_triggered;
    assign TRIG_ADDR   = r_trig_addr;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb_la_capture_ctrl
// Directed bench for la_capture_ctrl with ADDR_W=4: a frame-level model
// (sample stream, trigger index, expected frame) checked every cycle, plus
// hand-computed literal expectations per scenario.
module tb_la_capture_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          CLK;
    logic          RESET;
    logic          ARM;
    logic          SAMPLE_EN;
    logic [DW-1:0] LA_DATA_IN;
    logic          LA_Sync_RDY;
    logic [AW-1:0] PRETRIG_DEPTH;
    logic [AW-1:0] POSTTRIG_CNT;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          RD_REQ;
    logic [DW-1:0] LA_DATA_OUT;
    logic          RD_VALID;
    logic          RD_LAST;
    logic          BUSY;
    logic          TRIGGERED;
    logic          DONE;
    logic [AW-1:0] TRIG_ADDR;

    la_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET(RESET), .ARM(ARM), .SAMPLE_EN(SAMPLE_EN),
        .LA_DATA_IN(LA_DATA_IN), .LA_Sync_RDY(LA_Sync_RDY),
        .PRETRIG_DEPTH(PRETRIG_DEPTH), .POSTTRIG_CNT(POSTTRIG_CNT),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .RD_REQ(RD_REQ), .LA_DATA_OUT(LA_DATA_OUT),
        .RD_VALID(RD_VALID), .RD_LAST(RD_LAST), .BUSY(BUSY),
        .TRIGGERED(TRIGGERED), .DONE(DONE), .TRIG_ADDR(TRIG_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous sample RAM, one-cycle read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= ram[MEM_ADDR];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit m_en   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int            m_pre, m_post, m_n, m_t, m_rd_idx, m_start, m_i1;
    bit            m_capt, m_rdy, m_trg, m_v1, m_l1, m_v2, m_l2;
    logic [AW-1:0] m_taddr;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_stream[$];
    logic [DW-1:0] m_frame[$];

    task automatic model_step();
        bit acc;
        if (RESET) begin
            m_capt = 0; m_rdy = 0; m_trg = 0; m_taddr = '0; m_dout = '0;
            m_n = 0; m_t = -1; m_rd_idx = 0; m_start = 0; m_pre = 0; m_post = 0;
            m_v1 = 0; m_l1 = 0; m_v2 = 0; m_l2 = 0; m_i1 = 0;
            m_stream.delete(); m_frame.delete();
        end else begin
            acc = m_rdy && RD_REQ && !ARM && (m_rd_idx < m_frame.size());
            if (m_v2 && m_l2) begin m_rdy = 0; m_trg = 0; end
            if (m_v1) m_dout = m_frame[m_i1];
            m_v2 = m_v1; m_l2 = m_l1;
            m_v1 = acc; m_l1 = acc && (m_rd_idx == m_frame.size() - 1); m_i1 = m_rd_idx;
            if (acc) m_rd_idx++;
            if (ARM && !m_capt) begin
                m_pre  = int'(PRETRIG_DEPTH);
                m_post = int'(POSTTRIG_CNT);
                if (m_post > DEPTH - 1 - m_pre) m_post = DEPTH - 1 - m_pre;
                m_capt = 1; m_rdy = 0; m_trg = 0; m_n = 0; m_t = -1; m_rd_idx = 0;
                m_v1 = 0; m_l1 = 0; m_v2 = 0; m_l2 = 0;
                m_stream.delete(); m_frame.delete();
            end else if (m_capt && SAMPLE_EN) begin
                m_stream.push_back(LA_DATA_IN);
                if (m_t < 0 && m_n >= m_pre && LA_Sync_RDY) begin
                    m_t = m_n; m_trg = 1; m_taddr = m_n[AW-1:0];
                end
                m_n++;
                if (m_t >= 0 && m_n == m_t + m_post + 1) begin
                    m_capt = 0; m_rdy = 1; m_rd_idx = 0;
                    m_start = (m_t - m_pre) % DEPTH;
                    for (int k = m_t - m_pre; k <= m_t + m_post; k++) m_frame.push_back(m_stream[k]);
                end
            end
        end
    endtask

    logic [DW-1:0] rd_q[$];
    bit            rl_q[$];
    int            rc_q[$];

    task automatic compare_step();
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        int            ra;
        e_we = m_capt && SAMPLE_EN;
        e_wd = e_we ? LA_DATA_IN : '0;
        ra   = m_start + m_rd_idx;
        if (m_capt)     e_addr = m_n[AW-1:0];
        else if (m_rdy) e_addr = ra[AW-1:0];
        else            e_addr = '0;
        chk("mem_we", MEM_WE, e_we);
        chk("mem_addr", MEM_ADDR, e_addr);
        chk("mem_wdata", MEM_WDATA, e_wd);
        chk("busy", BUSY, m_capt);
        chk("done", DONE, m_rdy);
        chk("triggered", TRIGGERED, m_trg);
        chk("trig_addr", TRIG_ADDR, m_taddr);
        chk("rd_valid", RD_VALID, m_v2);
        chk("rd_last", RD_LAST, m_v2 && m_l2);
        chk("la_data_out", LA_DATA_OUT, m_dout);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (m_en) compare_step();
        if (RD_VALID) begin
            rd_q.push_back(LA_DATA_OUT);
            rl_q.push_back(RD_LAST);
            rc_q.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_q();
        rd_q.delete(); rl_q.delete(); rc_q.delete();
    endtask

    task automatic run_frame(input int pre, input int post, input int period,
                             input logic [63:0] mask, input logic [7:0] base,
                             input int max_cyc, input bit need_done);
        int i;
        ARM = 1'b1;
        PRETRIG_DEPTH = pre[AW-1:0];
        POSTTRIG_CNT  = post[AW-1:0];
        tick();
        ARM = 1'b0;
        i = 0;
        while (i < max_cyc && !(need_done && DONE)) begin
            SAMPLE_EN   = ((i % period) == 0);
            LA_DATA_IN  = base + 8'(i);
            LA_Sync_RDY = (i < 64) ? mask[i] : 1'b0;
            tick();
            i++;
        end
        SAMPLE_EN = 1'b0;
        LA_Sync_RDY = 1'b0;
        if (need_done) chk("capture_done", DONE, 1'b1);
    endtask

    task automatic rd_burst(input int n);
        RD_REQ = 1'b1;
        repeat (n) tick();
        RD_REQ = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [29:0] all_outs();
        return {MEM_WE, MEM_ADDR, MEM_WDATA, LA_DATA_OUT, RD_VALID, RD_LAST,
                BUSY, TRIGGERED, DONE, TRIG_ADDR};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        RESET = 1'b1; ARM = 1'b0; SAMPLE_EN = 1'b0; LA_DATA_IN = '0;
        LA_Sync_RDY = 1'b0; PRETRIG_DEPTH = '0; POSTTRIG_CNT = '0; RD_REQ = 1'b0;
        repeat (3) tick();
        m_en = 1;
        RESET = 1'b0;
        chk("reset_outputs", all_outs(), 30'd0);
        tick();

        // Basic frame: PRE=3 POST=2, trigger on sample 0x07
        run_frame(3, 2, 1, 64'h80, 8'h00, 40, 1);
        chk("basic_trig_addr", TRIG_ADDR, 4'd7);
        clear_q();
        rd_burst(6);
        chk("basic_count", rd_q.size(), 6);
        for (int k = 0; k < 6 && k < rd_q.size(); k++) begin
            chk("basic_data", rd_q[k], 32'(4 + k));
            chk("basic_last", rl_q[k], (k == 5));
        end
        chk("basic_idle", {BUSY, DONE}, 2'b00);

        // Trigger held high from ARM: ignored during PRE
        run_frame(4, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 40, 1);
        chk("pre_ign_trig_addr", TRIG_ADDR, 4'd4);
        chk("pre_ign_start_addr", MEM_ADDR, 4'd0);
        clear_q();
        rd_burst(6);
        chk("pre_ign_count", rd_q.size(), 6);
        if (rd_q.size() == 6) begin
            chk("pre_ign_first", rd_q[0], 8'h00);
            chk("pre_ign_last", rd_q[5], 8'h05);
        end

        // Wrap and clamp: PRE=10, POST 15 clamps to 5, trigger at wr_ptr 13
        run_frame(10, 15, 1, 64'h2000, 8'h80, 40, 1);
        chk("wrap_trig_addr", TRIG_ADDR, 4'd13);
        chk("wrap_start_addr", MEM_ADDR, 4'd3);
        clear_q();
        rd_burst(18);
        chk("wrap_count", rd_q.size(), 16);
        if (rd_q.size() == 16) begin
            chk("wrap_first", rd_q[0], 8'h83);
            chk("wrap_addr15", rd_q[12], 8'h8F);
            chk("wrap_addr0", rd_q[13], 8'h90);
            chk("wrap_final", rd_q[15], 8'h92);
            chk("wrap_final_last", rl_q[15], 1'b1);
        end

        // SAMPLE_EN every 3rd cycle, pulse on non-strobe (7) then strobe (9)
        run_frame(2, 2, 3, 64'h280, 8'h20, 60, 1);
        chk("gate_trig_addr", TRIG_ADDR, 4'd3);

        // Readout timing: 3 back-to-back requests, then the remainder
        clear_q();
        RD_REQ = 1'b1;
        r0 = cyc;
        repeat (3) tick();
        RD_REQ = 1'b0;
        repeat (3) tick();
        chk("rdt_count3", rd_q.size(), 3);
        for (int k = 0; k < 3 && k < rc_q.size(); k++) begin
            chk("rdt_cycle", rc_q[k], r0 + 2 + k);
        end
        if (rd_q.size() == 3) begin
            chk("rdt_d0", rd_q[0], 8'h23);
            chk("rdt_d1", rd_q[1], 8'h26);
            chk("rdt_d2", rd_q[2], 8'h29);
        end
        rd_burst(4);
        chk("rdt_count5", rd_q.size(), 5);
        if (rd_q.size() == 5) begin
            chk("rdt_d4", rd_q[4], 8'h2F);
            chk("rdt_last", rl_q[4], 1'b1);
        end

        // Reset mid-POST
        run_frame(1, 8, 1, 64'h4, 8'h50, 6, 0);
        chk("midpost_busy", BUSY, 1'b1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midpost_reset_outs", all_outs(), 30'd0);

        // Reset with a read in flight: no RD_VALID afterwards
        run_frame(2, 3, 1, 64'h10, 8'h60, 40, 1);
        clear_q();
        RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midread_reset_outs", all_outs(), 30'd0);
        repeat (3) tick();
        chk("midread_no_valid", rd_q.size(), 0);

        // Clean frame after reset: PRE=0 POST=0, single sample
        run_frame(0, 0, 1, 64'h4, 8'h70, 20, 1);
        chk("clean_trig_addr", TRIG_ADDR, 4'd2);
        clear_q();
        rd_burst(1);
        chk("clean_count", rd_q.size(), 1);
        if (rd_q.size() == 1) begin
            chk("clean_data", rd_q[0], 8'h72);
            chk("clean_last", rl_q[0], 1'b1);
        end
        chk("clean_idle", {BUSY, DONE, TRIGGERED}, 3'b000);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Capture controller for the logic-analyzer path. It consumes the trigger-ready level produced by the LA trigger/sync block together with the 8-bit LA sample stream. It writes samples into an external circular sample RAM with a programmable pre-trigger and post-trigger depth. After capture it hands the frame back to the MCU side sample by sample, oldest first, over a request/valid read handshake.

## Interface
- ADDR_W, 10, sample RAM address width; buffer depth 2^ADDR_W samples
- DATA_W, 8, LA sample width
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- ARM  in  1  one-cycle pulse: start a capture
- SAMPLE_EN  in  1  sample strobe from the rate divider; a sample is taken only on cycles with SAMPLE_EN=1
- LA_DATA_IN  in  DATA_W  current LA sample
- LA_Sync_RDY  in  1  trigger condition, aligned to LA_DATA_IN of the same cycle
- PRETRIG_DEPTH  in  ADDR_W  number of samples kept before the trigger sample; latched at ARM
- POSTTRIG_CNT  in  ADDR_W  number of samples kept after the trigger sample; latched at ARM
- MEM_WE  out  1  RAM write enable
- MEM_ADDR  out  ADDR_W  RAM address, shared by write and read
- MEM_WDATA  out  DATA_W  RAM write data
- MEM_RDATA  in  DATA_W  RAM read data, valid 1 cycle after the address (synchronous RAM)
- RD_REQ  in  1  request the next readout sample
- LA_DATA_OUT  out  DATA_W  readout sample, registered
- RD_VALID  out  1  one-cycle pulse: LA_DATA_OUT holds a new sample
- RD_LAST  out  1  set together with RD_VALID on the final sample of the frame
- BUSY  out  1  capture in progress (PRE, WAIT, POST)
- TRIGGERED  out  1  trigger accepted in the current frame
- DONE  out  1  frame complete, readout allowed
- TRIG_ADDR  out  ADDR_W  RAM address of the trigger sample

## Operation
- States: IDLE, PRE, WAIT, POST, DONE.
- IDLE + ARM:
  - Latch PRE=PRETRIG_DEPTH.
  - Latch POST=min(POSTTRIG_CNT, 2^ADDR_W-1-PRE).
  - Clear wr_ptr and TRIGGERED.
  - Go to PRE, or to WAIT if PRE=0.
- In PRE, WAIT and POST, every SAMPLE_EN cycle does the following, then increments wr_ptr modulo 2^ADDR_W (wrap is free, never an error):
  - MEM_WE=1
  - MEM_ADDR=wr_ptr
  - MEM_WDATA=LA_DATA_IN
- MEM_WE=0 on all other cycles and in all other states.
- PRE: LA_Sync_RDY is ignored. The pre-count increments per sample. On the PRE-th sample, go to WAIT.
- WAIT: on the first cycle with SAMPLE_EN=1 and LA_Sync_RDY=1, that sample is the trigger sample:
  - TRIG_ADDR <= wr_ptr, TRIGGERED <= 1, post-count <= POST.
  - Go to POST, or to DONE if POST=0.
  - LA_Sync_RDY with SAMPLE_EN=0 is ignored.
- POST: the post-count decrements per sample. The sample that brings it to 0 is the last one written; then go to DONE.
- DONE:
  - Set DONE=1.
  - rd_ptr = TRIG_ADDR - PRE (mod 2^ADDR_W).
  - Remaining count = PRE + POST + 1; this is always ≤ 2^ADDR_W thanks to the clamp.
  - MEM_ADDR = rd_ptr.
- Readout: an accepted RD_REQ increments rd_ptr and decrements the remaining count. RD_REQ is ignored when the remaining count is 0 or the state is not DONE.
- DONE → IDLE on the cycle after the RD_VALID that carries RD_LAST. DONE and TRIGGERED clear at that point.
- ARM in PRE/WAIT/POST is ignored. ARM in DONE abandons the frame and restarts exactly as from IDLE.
- RESET has priority over everything and can arrive mid-capture or mid-readout:
  - State → IDLE.
  - All outputs → 0, all pointers and counters → 0.
  - Any in-flight read is dropped; no RD_VALID follows.

## Timing
- Reset values: every output is 0, including MEM_ADDR and LA_DATA_OUT.
- ARM sampled at edge N: BUSY=1 from cycle N+1. The first possible write is in cycle N+1.
- Write path is zero latency: MEM_WE/MEM_ADDR/MEM_WDATA are valid in the same cycle as the SAMPLE_EN sample.
- Trigger sample at cycle T: TRIGGERED=1 and TRIG_ADDR valid from T+1.
- Last post sample at cycle L: BUSY=0 and DONE=1 from L+1.
- RD_REQ accepted at cycle R:
  - MEM_ADDR=rd_ptr during R.
  - MEM_RDATA is valid in R+1 and is registered into LA_DATA_OUT.
  - RD_VALID=1 in R+2 only.
- Back-to-back RD_REQ on consecutive cycles is allowed and gives one RD_VALID per cycle, each two cycles after its request.
- Throughput is one sample per SAMPLE_EN during capture, and one sample per clock during readout.

## Test plan
- Basic frame (ADDR_W=4): PRE=3, POST=2, SAMPLE_EN=1, data counts 0x00,0x01,…, trigger at the sample 0x07 → TRIG_ADDR=7. Readout of 6 samples gives 0x04,0x05,0x06,0x07,0x08,0x09, with RD_LAST on 0x09, then IDLE.
- Trigger ignored during PRE: PRE=4, LA_Sync_RDY=1 from ARM onward → the trigger sample is the 5th sample (TRIG_ADDR=4) and the readout starts at address 0.
- Wrap and clamp (ADDR_W=4): PRE=10, POSTTRIG_CNT=15 → POST clamps to 5 and exactly 16 samples are read back. Trigger at wr_ptr=13 → readout starts at addr 3 and wraps 15→0.
- SAMPLE_EN gating: SAMPLE_EN every 3rd cycle, with LA_Sync_RDY pulsed on a non-strobe cycle → no trigger. A pulse on a strobe cycle → trigger, and only strobed samples are written.
- Readout timing: RD_REQ held high for 3 cycles from R → RD_VALID high in R+2, R+3 and R+4, with sequential data. RD_REQ after the last sample → no RD_VALID.
- RESET mid-POST and mid-readout → next cycle all outputs are 0 and state is IDLE, with no stray RD_VALID. A following ARM starts a clean frame.
